// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment glyphs and watch mode codes
package seven_seg_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    typedef enum logic [1:0] {
        RELOGIO    = 2'b00,
        CRONOMETRO = 2'b01,
        CFG        = 2'b10
    } mode_e;

    function automatic logic [2:0] mode_to_led(input logic [1:0] mode);
        case (mode)
            RELOGIO:    mode_to_led = 3'b001;
            CRONOMETRO: mode_to_led = 3'b010;
            CFG:        mode_to_led = 3'b100;
            default:    mode_to_led = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-low seven-segment decoder
module bcd_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_display.sv
// rtl/seven_seg_display.sv - six-digit display driver with config-digit blink and mode LEDs
module seven_seg_display
    import seven_seg_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BLINK_HZ       = 2,
    parameter int BLANK_H_DEZENA = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s_unidade,
    input  logic [3:0] s_dezena,
    input  logic [3:0] m_unidade,
    input  logic [3:0] m_dezena,
    input  logic [3:0] h_unidade,
    input  logic [3:0] h_dezena,
    input  logic [1:0] state,
    input  logic       is_config,
    input  logic [2:0] config_digit,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic [2:0] led_mode,
    output logic       blink_phase
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);

    logic [3:0]    digit [6];
    logic [6:0]    glyph [6];
    logic [6:0]    hex_d [6];
    logic [6:0]    hex_q [6];
    logic [CW-1:0] cnt_d, cnt_q;
    logic          blink_phase_d, blink_phase_q;
    logic          prev_is_config_q;
    logic [2:0]    prev_config_digit_q;
    logic [2:0]    led_mode_d, led_mode_q;
    logic          restart;

    assign digit[0] = s_unidade;
    assign digit[1] = s_dezena;
    assign digit[2] = m_unidade;
    assign digit[3] = m_dezena;
    assign digit[4] = h_unidade;
    assign digit[5] = h_dezena;

    for (genvar i = 0; i < 6; i++) begin : g_dec
        bcd_to_seg7 u_dec (
            .bcd (digit[i]),
            .seg (glyph[i])
        );
    end

    always_comb begin
        // A fresh selection always starts with a full ON half-period
        restart = is_config &&
                  (!prev_is_config_q || (config_digit != prev_config_digit_q));
        cnt_d         = cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (restart) begin
            cnt_d         = '0;
            blink_phase_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d         = '0;
            blink_phase_d = !blink_phase_q;
        end

        // Blank against the phase being registered so hex and blink_phase stay aligned
        for (int i = 0; i < 6; i++) begin
            hex_d[i] = glyph[i];
            if ((i == 5) && (BLANK_H_DEZENA != 0) && !is_config && (h_dezena == 4'd0))
                hex_d[i] = SEG_BLANK;
            if (is_config && !blink_phase_d && (config_digit == i[2:0]))
                hex_d[i] = SEG_BLANK;
        end

        led_mode_d = mode_to_led(state);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
            led_mode_q          <= 3'b000;
            blink_phase_q       <= 1'b1;
            cnt_q               <= '0;
            prev_is_config_q    <= 1'b0;
            prev_config_digit_q <= 3'd0;
        end else begin
            for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
            led_mode_q          <= led_mode_d;
            blink_phase_q       <= blink_phase_d;
            cnt_q               <= cnt_d;
            prev_is_config_q    <= is_config;
            prev_config_digit_q <= config_digit;
        end
    end

    assign hex0        = hex_q[0];
    assign hex1        = hex_q[1];
    assign hex2        = hex_q[2];
    assign hex3        = hex_q[3];
    assign hex4        = hex_q[4];
    assign hex5        = hex_q[5];
    assign led_mode    = led_mode_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seven_seg_display.sv
// tb/tb_seven_seg_display.sv - self-checking bench for seven_seg_display
module tb_seven_seg_display;

    localparam int CLK_HZ   = 8;
    localparam int BLINK_HZ = 1;
    localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena;
    logic [1:0] state;
    logic       is_config;
    logic [2:0] config_digit;
    logic [6:0] ha0, ha1, ha2, ha3, ha4, ha5;
    logic [6:0] hb0, hb1, hb2, hb3, hb4, hb5;
    logic [2:0] led_a, led_b;
    logic       ph_a, ph_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seven_seg_display #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .BLANK_H_DEZENA(0)) dut_a (
        .clk(clk), .reset(reset),
        .s_unidade(s_unidade), .s_dezena(s_dezena), .m_unidade(m_unidade),
        .m_dezena(m_dezena), .h_unidade(h_unidade), .h_dezena(h_dezena),
        .state(state), .is_config(is_config), .config_digit(config_digit),
        .hex0(ha0), .hex1(ha1), .hex2(ha2), .hex3(ha3), .hex4(ha4), .hex5(ha5),
        .led_mode(led_a), .blink_phase(ph_a)
    );

    seven_seg_display #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .BLANK_H_DEZENA(1)) dut_b (
        .clk(clk), .reset(reset),
        .s_unidade(s_unidade), .s_dezena(s_dezena), .m_unidade(m_unidade),
        .m_dezena(m_dezena), .h_unidade(h_unidade), .h_dezena(h_dezena),
        .state(state), .is_config(is_config), .config_digit(config_digit),
        .hex0(hb0), .hex1(hb1), .hex2(hb2), .hex3(hb3), .hex4(hb4), .hex5(hb5),
        .led_mode(led_b), .blink_phase(ph_b)
    );

    logic [6:0] act_a [6];
    logic [6:0] act_b [6];
    assign act_a = '{ha0, ha1, ha2, ha3, ha4, ha5};
    assign act_b = '{hb0, hb1, hb2, hb3, hb4, hb5};

    // Reference model: phase from elapsed cycles since the last restart anchor
    int         m_n;
    logic       m_pic;
    logic [2:0] m_pcd;
    logic       e_ph;
    logic [2:0] e_led;
    logic [6:0] e_a [6];
    logic [6:0] e_b [6];

    function automatic logic [6:0] glyph_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic model_reset();
        m_n   = 0;
        m_pic = 1'b0;
        m_pcd = 3'd0;
        e_ph  = 1'b1;
        e_led = 3'b000;
        for (int i = 0; i < 6; i++) begin
            e_a[i] = 7'h7F;
            e_b[i] = 7'h7F;
        end
    endtask

    task automatic model_edge();
        logic [3:0] d [6];
        d = '{s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena};
        if (is_config && (!m_pic || config_digit != m_pcd)) m_n = 0;
        else m_n = m_n + 1;
        m_pic = is_config;
        m_pcd = config_digit;
        e_ph  = ((m_n / HALF) % 2) == 0;
        e_led = (state == 2'd3) ? 3'b000 : (3'b001 << state);
        for (int i = 0; i < 6; i++) begin
            e_a[i] = glyph_of(d[i]);
            e_b[i] = (i == 5 && !is_config && d[5] == 4'd0) ? 7'h7F : glyph_of(d[i]);
            if (is_config && !e_ph && int'(config_digit) == i) begin
                e_a[i] = 7'h7F;
                e_b[i] = 7'h7F;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s hexA%0d", tag, i), 32'(act_a[i]), 32'(e_a[i]));
            chk($sformatf("%s hexB%0d", tag, i), 32'(act_b[i]), 32'(e_b[i]));
        end
        chk({tag, " ledA"}, 32'(led_a), 32'(e_led));
        chk({tag, " ledB"}, 32'(led_b), 32'(e_led));
        chk({tag, " phaseA"}, 32'(ph_a), 32'(e_ph));
        chk({tag, " phaseB"}, 32'(ph_b), 32'(e_ph));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
        s_unidade = a; s_dezena = b; m_unidade = c;
        m_dezena  = d; h_unidade = e; h_dezena = f;
    endtask

    typedef struct {
        logic [3:0] d;
        logic [1:0] st;
        logic [6:0] seg;
        logic [2:0] led;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{4'h0, 2'd0, 7'h40, 3'b001};  tbl[1]  = '{4'h1, 2'd1, 7'h79, 3'b010};
        tbl[2]  = '{4'h2, 2'd2, 7'h24, 3'b100};  tbl[3]  = '{4'h3, 2'd3, 7'h30, 3'b000};
        tbl[4]  = '{4'h4, 2'd0, 7'h19, 3'b001};  tbl[5]  = '{4'h5, 2'd1, 7'h12, 3'b010};
        tbl[6]  = '{4'h6, 2'd2, 7'h02, 3'b100};  tbl[7]  = '{4'h7, 2'd3, 7'h78, 3'b000};
        tbl[8]  = '{4'h8, 2'd0, 7'h00, 3'b001};  tbl[9]  = '{4'h9, 2'd1, 7'h10, 3'b010};
        tbl[10] = '{4'hA, 2'd2, 7'h3F, 3'b100};  tbl[11] = '{4'hB, 2'd3, 7'h3F, 3'b000};
        tbl[12] = '{4'hC, 2'd0, 7'h3F, 3'b001};  tbl[13] = '{4'hD, 2'd1, 7'h3F, 3'b010};
        tbl[14] = '{4'hE, 2'd2, 7'h3F, 3'b100};  tbl[15] = '{4'hF, 2'd3, 7'h3F, 3'b000};

        reset = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        state = 2'd0; is_config = 1'b0; config_digit = 3'd0;
        #1 reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset hex0 blank", 32'(ha0), 32'h7F);

        reset = 1'b1;
        tick("release");
        chk("release hex0", 32'(ha0), 32'h79);
        chk("release hex5", 32'(ha5), 32'h02);
        chk("release led", 32'(led_a), 32'b001);

        for (int k = 0; k < 16; k++) begin
            s_dezena = tbl[k].d;
            state    = tbl[k].st;
            tick("table");
            chk($sformatf("table hex1[%0d]", k), 32'(ha1), 32'(tbl[k].seg));
            chk($sformatf("table led[%0d]", k), 32'(led_a), 32'(tbl[k].led));
        end
        s_dezena = 4'd2;
        state    = 2'd2;

        // Config on digit 2: four ON cycles then four OFF; switch to digit 3 mid-OFF
        is_config = 1'b1; config_digit = 3'd2;
        for (int k = 0; k < 6; k++) begin
            tick("blink2");
            chk($sformatf("blink2 phase[%0d]", k), 32'(ph_a), 32'(k < 4));
            chk($sformatf("blink2 hex2[%0d]", k), 32'(ha2), (k < 4) ? 32'h30 : 32'h7F);
            chk($sformatf("blink2 hex1[%0d]", k), 32'(ha1), 32'h24);
        end
        config_digit = 3'd3;
        for (int k = 0; k < 5; k++) begin
            tick("blink3");
            chk($sformatf("blink3 phase[%0d]", k), 32'(ph_a), 32'(k < 4));
            chk($sformatf("blink3 hex2[%0d]", k), 32'(ha2), 32'h30);
            chk($sformatf("blink3 hex3[%0d]", k), 32'(ha3), (k < 4) ? 32'h19 : 32'h7F);
        end

        // Leaving config: blanked digit returns immediately
        is_config = 1'b0;
        tick("leave");
        chk("leave hex3", 32'(ha3), 32'h19);

        is_config = 1'b1; config_digit = 3'd6;
        for (int k = 0; k < 2 * HALF + 1; k++) begin
            tick("cfg6");
            chk($sformatf("cfg6 noblank[%0d]", k),
                32'((ha0 == 7'h7F) || (ha1 == 7'h7F) || (ha2 == 7'h7F) ||
                    (ha3 == 7'h7F) || (ha4 == 7'h7F) || (ha5 == 7'h7F)), 32'd0);
        end

        // Leading-zero blank on the BLANK_H_DEZENA=1 instance
        h_dezena = 4'd0; is_config = 1'b0; state = 2'd0;
        tick("lz0");
        chk("lz0 hexB5", 32'(hb5), 32'h7F);
        chk("lz0 hexA5", 32'(ha5), 32'h40);
        state = 2'd2; is_config = 1'b1; config_digit = 3'd5;
        tick("lzcfg");
        chk("lzcfg hexB5", 32'(hb5), 32'h40);
        state = 2'd3; is_config = 1'b0;
        tick("lz3");
        chk("lz3 ledB", 32'(led_b), 32'b000);
        chk("lz3 hexB5", 32'(hb5), 32'h7F);

        // Reset mid-blink: asynchronous blank and counter clear
        is_config = 1'b1; config_digit = 3'd1;
        repeat (HALF + 1) tick("preRst");
        chk("preRst hex1 off", 32'(ha1), 32'h7F);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("midRst");
        @(negedge clk);
        check_all("midRstHold");
        reset = 1'b1;
        tick("postRst");
        chk("postRst phase", 32'(ph_a), 32'd1);

        for (int k = 0; k < 400; k++) begin
            set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) is_config = ~is_config;
            if ($urandom_range(0, 9) == 0) config_digit = 3'($urandom_range(0, 7));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_display.md
Name: seven_seg_display

Overview:
- Downstream stage of the watch mode FSM.
- Consumes the six BCD digits, the state code, is_config and config_digit.
- Drives six active-low seven-segment displays (hex0 = seconds unit … hex5 = hours tens) and three one-hot mode LEDs.
- In configuration mode, the digit under edit blinks at BLINK_HZ. All outputs are registered.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- BLINK_HZ, 2, full blink cycles per second. Half-period HALF = CLK_HZ/(2*BLINK_HZ), which must be ≥2.
- BLANK_H_DEZENA, 0, when 1, hex5 is blanked if the hours-tens digit is 0 outside config mode.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- s_unidade  in  4  seconds unit, BCD
- s_dezena  in  4  seconds tens, BCD
- m_unidade  in  4  minutes unit, BCD
- m_dezena  in  4  minutes tens, BCD
- h_unidade  in  4  hours unit, BCD
- h_dezena  in  4  hours tens, BCD
- state  in  2  mode code: 0 RELOGIO, 1 CRONOMETRO, 2 CFG
- is_config  in  1  configuration mode active
- config_digit  in  3  digit under edit: 0 = s_unidade … 5 = h_dezena
- hex0..hex5  out  7 each  segments {g,f,e,d,c,b,a}, active-low
- led_mode  out  3  one-hot mode indicator
- blink_phase  out  1  1 = ON half-period, 0 = OFF half-period

Behaviour:
- Reset (asynchronous, reset=0):
  - hex0..hex5 = 7'h7F (blank); led_mode = 0; blink_phase = 1; blink counter = 0; prev_is_config = 0; prev_config_digit = 0.
- Latency: every output reflects the inputs sampled at the previous clk edge (1 cycle).
- Decode per digit:
  - 0-9 gives the standard glyphs, e.g. 0 = 7'h40, 1 = 7'h79, 8 = 7'h00.
  - 10-15 gives a dash, 7'h3F.
- Blink timer:
  - The counter increments every cycle.
  - At HALF-1 the counter wraps to 0 and blink_phase toggles.
  - The counter runs freely regardless of mode.
- Blink restart:
  - Condition: a rising edge of is_config, or config_digit differing from its registered previous value while is_config=1.
  - Effect: next cycle counter = 0 and blink_phase = 1, so the new selection is first shown ON for a full HALF.
  - Restart has priority over a simultaneous wrap/toggle.
- Blanking:
  - If is_config=1, blink_phase=0 and config_digit ≤ 5, hex[config_digit] = 7'h7F.
  - config_digit 6 or 7 blanks nothing.
  - Other digits are unaffected.
- Leading-zero blank: if BLANK_H_DEZENA=1, is_config=0 and h_dezena=0, then hex5 = 7'h7F.
- Priority: config blanking, then leading-zero blank, then decoded glyph.
- led_mode:
  - state 0 gives 3'b001, 1 gives 3'b010, 2 gives 3'b100.
  - state 3 gives 3'b000, and hex outputs still decode normally.
- Leaving config (is_config 1→0): the blanked digit reappears on the next cycle; the blink counter keeps running.
- Reset mid-blink: immediate blank and counter clear; after release the first display update occurs on the first clk edge.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F;
  - the digit glyph constants;
  - mode codes RELOGIO = 2'b00, CRONOMETRO = 2'b01, CFG = 2'b10, shared with the FSM.
- Sub-module bcd_to_seg7: purely combinational, 4-bit in, 7-bit active-low out, instantiated six times.
- Blink timer, blanking muxes and output registers live in the top module.

Test Plan (CLK_HZ=8, BLINK_HZ=1, so HALF=4):
- Reset held, then released with digits 1,2,3,4,5,6 and state=0 → all hex = 7'h7F during reset. One cycle after release: hex0 = 7'h79 ('1') … hex5 = glyph '6', led_mode = 3'b001.
- Digit input 4'hB on s_dezena → hex1 = 7'h3F next cycle; 4'h9 → glyph '9'.
- is_config rises with config_digit=2 → blink_phase = 1 for 4 cycles, then 0 for 4 cycles. hex2 = 7'h7F only during the 0 phase; hex0, hex1 and hex3-5 stay constant.
- During the OFF phase, config_digit changes 2→3 → next cycle blink_phase = 1, counter = 0, hex2 shows its glyph. hex3 then blanks 4 cycles later.
- config_digit=6 with is_config=1 across a full blink period → no hex ever blanked.
- BLANK_H_DEZENA=1, h_dezena=0:
  - state=0 → hex5 = 7'h7F;
  - state=2/is_config=1 → hex5 = 7'h40 in ON phase;
  - state=3 → led_mode = 0.
